// File: rtl/cascade_bcd_timer.sv
// Cascaded multi-digit BCD timer with per-digit modulus (default mm:ss).
// Digit 0 is least significant. Supports preset load, start/pause/clear,
// direction latched at start, and stop-at-terminal or wrap-around modes.
module cascade_bcd_timer #(
  parameter int unsigned         DIGITS           = 4,
  parameter logic [4*DIGITS-1:0] MODS             = {4'd6, 4'd10, 4'd6, 4'd10},
  parameter bit                  STOP_AT_TERMINAL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  dir,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done,
  output logic                  expired,
  output logic                  ceo
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e              state_q, state_d;
  logic                dir_q;
  logic                done_q, done_d;
  logic [4*DIGITS-1:0] count_q, count_d, count_step, load_clamped;
  logic [DIGITS-1:0]   en, term_run, term_start, term_step;
  logic                carry, tick_ok, start_ok, hit;

  // Largest legal value of digit i.
  function automatic logic [3:0] mod_max(input int unsigned i);
    return MODS[4*i +: 4] - 4'd1;
  endfunction

  // Per-digit terminal flags: for the latched direction and for the one offered at start.
  always_comb begin
    term_run   = '0;
    term_start = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      term_run[i]   = dir_q ? (count_q[4*i +: 4] == mod_max(i)) : (count_q[4*i +: 4] == 4'd0);
      term_start[i] = dir   ? (count_q[4*i +: 4] == mod_max(i)) : (count_q[4*i +: 4] == 4'd0);
    end
  end

  // A tick only counts in RUN and when no higher-priority control is present.
  assign tick_ok  = tick & (state_q == StRun) & ~clear & ~load & ~pause;
  assign start_ok = start & ~pause & (state_q != StRun) &
                    ~(STOP_AT_TERMINAL & (&term_start));
  assign ceo      = tick & (state_q == StRun) & (&term_run);

  // Ripple the enable up the chain and step every enabled digit.
  always_comb begin
    en         = '0;
    count_step = count_q;
    term_step  = '0;
    carry      = tick_ok;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      en[i] = carry;
      carry = carry & term_run[i];
      if (en[i]) begin
        if (dir_q) begin
          count_step[4*i +: 4] = term_run[i] ? 4'd0 : count_q[4*i +: 4] + 4'd1;
        end else begin
          count_step[4*i +: 4] = term_run[i] ? mod_max(i) : count_q[4*i +: 4] - 4'd1;
        end
      end
      term_step[i] = dir_q ? (count_step[4*i +: 4] == mod_max(i))
                           : (count_step[4*i +: 4] == 4'd0);
    end
  end

  assign hit = STOP_AT_TERMINAL & tick_ok & (&term_step);

  // Clamp each preset digit to its modulus.
  always_comb begin
    load_clamped = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      load_clamped[4*i +: 4] = (load_value[4*i +: 4] > mod_max(i)) ? mod_max(i)
                                                                   : load_value[4*i +: 4];
    end
  end

  // Count and done-pulse next state, clear over load over counting.
  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_clamped;
    end else begin
      count_d = count_step;
      done_d  = hit;
    end
  end

  // FSM next state in input-priority order.
  always_comb begin
    state_d = state_q;
    if (clear || load) begin
      state_d = StIdle;
    end else if (pause) begin
      if (state_q == StRun) state_d = StPause;
    end else if (start_ok) begin
      state_d = StRun;
    end else if (hit) begin
      state_d = StDone;
    end
  end

  // State, direction, count and done registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      dir_q   <= 1'b0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      if (!clear && !load && start_ok) dir_q <= dir;
    end
  end

  // Outputs decoded from state and registers.
  always_comb begin
    running = (state_q == StRun);
    expired = (state_q == StDone);
    done    = done_q;
    count   = count_q;
  end

endmodule

// File: tb/tb_cascade_bcd_timer.sv
// Bench for cascade_bcd_timer: one stop-at-terminal and one wrapping instance
// driven in lockstep, compared every cycle against a mixed-radix integer model.
module tb_cascade_bcd_timer;

  localparam int TOTAL = 3600;
  int mods [4] = '{10, 6, 10, 6};

  logic        clk = 1'b0;
  logic        reset, tick, clear, load, start, pause, dir;
  logic [15:0] load_value;
  logic [15:0] cnt [2];
  logic        run_o [2], done_o [2], exp_o [2], ceo_o [2];
  logic        last_ceo [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Model state; index 0 = wrap instance, 1 = stop instance. st: 0 idle,1 run,2 pause,3 done
  int m_val [2];
  int m_st  [2];
  bit m_dir [2];
  bit m_done[2];

  always #5 clk = ~clk;

  cascade_bcd_timer #(.STOP_AT_TERMINAL(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .tick(tick), .clear(clear), .load(load),
    .load_value(load_value), .start(start), .pause(pause), .dir(dir),
    .count(cnt[0]), .running(run_o[0]), .done(done_o[0]), .expired(exp_o[0]), .ceo(ceo_o[0])
  );

  cascade_bcd_timer #(.STOP_AT_TERMINAL(1'b1)) u_stop (
    .clk(clk), .reset(reset), .tick(tick), .clear(clear), .load(load),
    .load_value(load_value), .start(start), .pause(pause), .dir(dir),
    .count(cnt[1]), .running(run_o[1]), .done(done_o[1]), .expired(exp_o[1]), .ceo(ceo_o[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int term(input bit d);
    return d ? TOTAL - 1 : 0;
  endfunction

  function automatic int clamp_val(input logic [15:0] b);
    int v = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      int n = int'((b >> (4 * i)) & 16'hf);
      if (n > mods[i] - 1) n = mods[i] - 1;
      v += n * w;
      w *= mods[i];
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b = '0;
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = 4'(v % mods[i]);
      v = v / mods[i];
    end
    return b;
  endfunction

  task automatic model_update(input int k, input bit r, c, l, input logic [15:0] lv,
                              input bit p, s, d, t);
    bit stop = (k == 1);
    if (r) begin
      m_val[k] = 0; m_st[k] = 0; m_dir[k] = 0; m_done[k] = 0;
    end else begin
      m_done[k] = 0;
      if (c) begin
        m_val[k] = 0; m_st[k] = 0;
      end else if (l) begin
        m_val[k] = clamp_val(lv); m_st[k] = 0;
      end else if (p) begin
        if (m_st[k] == 1) m_st[k] = 2;
      end else if (s && m_st[k] != 1) begin
        if (!(stop && m_val[k] == term(d))) begin
          m_dir[k] = d; m_st[k] = 1;
        end
      end else if (t && m_st[k] == 1) begin
        m_val[k] = m_dir[k] ? (m_val[k] + 1) % TOTAL : (m_val[k] + TOTAL - 1) % TOTAL;
        if (stop && m_val[k] == term(m_dir[k])) begin
          m_st[k] = 3; m_done[k] = 1;
        end
      end
    end
  endtask

  task automatic step(input bit r, c, l, input logic [15:0] lv, input bit p, s, d, t);
    @(negedge clk);
    reset = r; clear = c; load = l; load_value = lv; pause = p; start = s; dir = d; tick = t;
    #1;
    for (int k = 0; k < 2; k++) begin
      last_ceo[k] = ceo_o[k];
      check($sformatf("ceo%0d", k), 32'(ceo_o[k]),
            32'(t && m_st[k] == 1 && m_val[k] == term(m_dir[k])));
      model_update(k, r, c, l, lv, p, s, d, t);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("count%0d", k), 32'(cnt[k]), 32'(to_bcd(m_val[k])));
      check($sformatf("running%0d", k), 32'(run_o[k]), 32'(m_st[k] == 1));
      check($sformatf("expired%0d", k), 32'(exp_o[k]), 32'(m_st[k] == 3));
      check($sformatf("done%0d", k), 32'(done_o[k]), 32'(m_done[k]));
    end
  endtask

  task automatic tk();
    step(0, 0, 0, 16'h0, 0, 0, 0, 1);
  endtask
  task automatic ld(input logic [15:0] v);
    step(0, 0, 1, v, 0, 0, 0, 0);
  endtask
  task automatic go(input bit d);
    step(0, 0, 0, 16'h0, 0, 1, d, 0);
  endtask

  initial begin
    reset = 1; clear = 0; load = 0; load_value = 0; pause = 0; start = 0; dir = 0; tick = 0;
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 0; m_st[k] = 0; m_dir[k] = 0; m_done[k] = 0;
    end
    repeat (2) @(posedge clk);
    step(1, 0, 0, 16'h0, 0, 0, 0, 0);
    check("rst_count", 32'(cnt[1]), 32'h0);
    check("rst_running", 32'(run_o[1]), 32'h0);

    // Down count to terminal with stop
    ld(16'h0003); go(0);
    tk(); check("tp1_c2", 32'(cnt[1]), 32'h0002);
    tk(); check("tp1_c1", 32'(cnt[1]), 32'h0001);
    tk(); check("tp1_c0", 32'(cnt[1]), 32'h0000);
    check("tp1_done", 32'(done_o[1]), 32'h1);
    check("tp1_expired", 32'(exp_o[1]), 32'h1);
    check("tp1_running", 32'(run_o[1]), 32'h0);
    tk(); check("tp1_hold", 32'(cnt[1]), 32'h0000);
    check("tp1_done_once", 32'(done_o[1]), 32'h0);

    // Cascaded borrow
    ld(16'h0100); go(0); tk(); check("tp2_a", 32'(cnt[1]), 32'h0059);
    ld(16'h1000); go(0); tk(); check("tp2_b", 32'(cnt[1]), 32'h0959);

    // Up count with wrap
    ld(16'h5958); go(1);
    tk(); check("tp3_5959", 32'(cnt[0]), 32'h5959);
    tk(); check("tp3_wrap", 32'(cnt[0]), 32'h0000);
    check("tp3_ceo", 32'(last_ceo[0]), 32'h1);
    check("tp3_done", 32'(done_o[0]), 32'h0);
    check("tp3_running", 32'(run_o[0]), 32'h1);

    // Pause / resume
    ld(16'h0010); go(0); tk(); tk();
    check("tp4_8", 32'(cnt[1]), 32'h0008);
    step(0, 0, 0, 16'h0, 1, 0, 0, 0);
    tk(); tk(); tk();
    check("tp4_hold", 32'(cnt[1]), 32'h0008);
    go(0); tk(); check("tp4_7", 32'(cnt[1]), 32'h0007);
    step(0, 0, 0, 16'h0, 1, 1, 0, 0);
    check("tp4_ps_run", 32'(run_o[1]), 32'h0);
    tk(); check("tp4_ps_hold", 32'(cnt[1]), 32'h0007);

    // Clamp and priority
    ld(16'h7A9F); check("tp5_clamp", 32'(cnt[1]), 32'h5959);
    step(0, 1, 1, 16'h1234, 0, 0, 0, 1);
    check("tp5_clr", 32'(cnt[1]), 32'h0000);
    go(0);
    check("tp5_nostart", 32'(run_o[1]), 32'h0);
    check("tp5_nodone", 32'(done_o[1]), 32'h0);

    // Reset mid-run
    ld(16'h0042); go(0); tk();
    check("tp6_41", 32'(cnt[1]), 32'h0041);
    step(1, 0, 0, 16'h0, 0, 0, 0, 1);
    check("tp6_cnt", 32'(cnt[1]), 32'h0000);
    check("tp6_run", 32'(run_o[1]), 32'h0);
    check("tp6_exp", 32'(exp_o[1]), 32'h0);

    // Randomized traffic, presets biased toward both ends of the range
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] lv;
      case ($urandom_range(0, 3))
        0:       lv = 16'($urandom);
        1:       lv = 16'($urandom_range(0, 5));
        2:       lv = 16'h5955 + 16'($urandom_range(0, 4));
        default: lv = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 9)),
                       4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
      endcase
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 5, lv, $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 12, 1'($urandom_range(0, 1)),
           $urandom_range(0, 99) < 70);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
